// File: rtl/ir_pdm_tx_arbiter.sv
// Round-robin owner of one ir_pdm_modulator; grants whole frames and feeds symbols one load at a time.
// Latency: 1 clk from the IDLE grant decision to mod_load; every output is a register.
// Backpressure: mod_done level paces the loads; an absent req[g] parks in HOLD; stalls time out to IDLE.
module ir_pdm_tx_arbiter #(
    parameter int N       = 4,
    parameter int SYM_W   = 5,
    parameter int GAP_CYC = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [N-1:0]           req,
    input  logic [N*SYM_W-1:0]     sym,
    input  logic [N-1:0]           sym_last,
    output logic [N-1:0]           sym_ready,
    output logic [N-1:0]           grant,
    output logic                   busy,
    output logic [SYM_W-1:0]       mod_din,
    output logic                   mod_load,
    input  logic                   mod_done,
    output logic                   frame_done,
    output logic [$clog2(N)-1:0]   frame_id,
    output logic                   err_timeout,
    input  logic                   err_clr
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_ACK, S_WAIT_DONE, S_HOLD, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     g_q, g_d, ptr_q, ptr_d, g_next, pick;
    logic              last_q, last_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [N-1:0]      grant_d, sym_ready_d;
    logic [SYM_W-1:0]  mod_din_d;
    logic              mod_load_d, frame_done_d, err_d, busy_d;
    logic [IW-1:0]     frame_id_d;
    logic              do_load, timeout;

    // Scan downwards so the requester closest to ptr is the one left in pick.
    always_comb begin
        pick = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % N]) pick = IW'((int'(ptr_q) + k) % N);
        end
    end

    assign g_next = (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        ptr_d        = ptr_q;
        last_d       = last_q;
        timer_d      = timer_q;
        gap_d        = gap_q;
        grant_d      = grant;
        mod_din_d    = mod_din;
        mod_load_d   = 1'b0;
        sym_ready_d  = '0;
        frame_done_d = 1'b0;
        frame_id_d   = frame_id;
        err_d        = err_clr ? 1'b0 : err_timeout;
        do_load      = 1'b0;
        timeout      = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && (|req) && mod_done) begin
                    g_d     = pick;
                    grant_d = N'(1) << pick;
                    do_load = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_ACK;
                timer_d = '0;
            end
            S_WAIT_ACK: begin
                if (!mod_done) begin
                    state_d = S_WAIT_DONE;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (mod_done) begin
                    if (last_q) begin
                        frame_done_d = 1'b1;
                        frame_id_d   = g_q;
                        ptr_d        = g_next;
                        grant_d      = '0;
                        gap_d        = '0;
                        state_d      = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    end else if (req[g_q]) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_HOLD: begin
                // Dropping en while starved abandons the frame rather than waiting forever.
                if (!en) begin
                    grant_d = '0;
                    ptr_d   = g_next;
                    state_d = S_IDLE;
                end else if (req[g_q]) begin
                    do_load = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) state_d = S_IDLE;
                else                           gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            grant_d = '0;
            ptr_d   = g_next;
            state_d = S_IDLE;
        end

        if (do_load) begin
            state_d     = S_LOAD;
            mod_load_d  = 1'b1;
            mod_din_d   = sym[int'(g_d) * SYM_W +: SYM_W];
            sym_ready_d = N'(1) << g_d;
            last_d      = sym_last[g_d];
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            ptr_q       <= '0;
            last_q      <= 1'b0;
            timer_q     <= '0;
            gap_q       <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            mod_din     <= '0;
            mod_load    <= 1'b0;
            sym_ready   <= '0;
            frame_done  <= 1'b0;
            frame_id    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            grant       <= grant_d;
            busy        <= busy_d;
            mod_din     <= mod_din_d;
            mod_load    <= mod_load_d;
            sym_ready   <= sym_ready_d;
            frame_done  <= frame_done_d;
            frame_id    <= frame_id_d;
            err_timeout <= err_d;
        end
    end

endmodule
